// File: rtl/shared_data_mem.sv
// shared_data_mem: N-port shared data memory with round-robin arbitration of same-address writes
module shared_data_mem #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CORES-1:0]          req,
    input  logic [NUM_CORES-1:0]          we,
    input  logic [NUM_CORES*ADDR_W-1:0]   addr,
    input  logic [NUM_CORES*DATA_W-1:0]   wdata,
    output logic [NUM_CORES-1:0]          gnt,
    output logic [NUM_CORES*DATA_W-1:0]   rdata,
    output logic [NUM_CORES-1:0]          rvalid,
    output logic [15:0]                   conflict_cnt
);
    localparam int PW = $clog2(NUM_CORES);
    localparam int MW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
    logic [DATA_W-1:0]           r_mem [DEPTH];
    logic [PW-1:0]               r_rr_ptr;
    logic [15:0]                 r_conflict_cnt;
    logic [NUM_CORES*DATA_W-1:0] r_rdata;
    logic [NUM_CORES-1:0]        r_rvalid;
    logic [NUM_CORES-1:0]        w_wr, w_rd, w_gnt, w_in_range;
    logic                        w_deny;
    // a writer loses only to a same-address writer closer to rr_ptr in scan order
    always_comb begin
        w_wr = req & we;
        w_rd = req & ~we;
        w_gnt = '0;
        w_in_range = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_in_range[i] = {1'b0, addr[i*ADDR_W +: ADDR_W]} < LIMIT;
            w_gnt[i] = w_rd[i] | w_wr[i];
            for (int j = 0; j < NUM_CORES; j++)
                if (j != i && w_wr[i] && w_wr[j] &&
                    addr[j*ADDR_W +: ADDR_W] == addr[i*ADDR_W +: ADDR_W] &&
                    ((j + NUM_CORES - int'(r_rr_ptr)) % NUM_CORES) <
                    ((i + NUM_CORES - int'(r_rr_ptr)) % NUM_CORES))
                    w_gnt[i] = 1'b0;
        end
        if (rst) w_gnt = '0;
        w_deny = |(w_wr & ~w_gnt) & ~rst;
    end
    // granted in-range writes land in storage; out-of-range ones are dropped
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CORES; i++)
            if (w_gnt[i] && we[i] && w_in_range[i])
                r_mem[addr[i*ADDR_W +: MW]] <= wdata[i*DATA_W +: DATA_W];
    end
    // read-first registered read port per core; out-of-range reads return zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_rd;
            for (int i = 0; i < NUM_CORES; i++)
                if (w_rd[i])
                    r_rdata[i*DATA_W +: DATA_W] <= w_in_range[i] ? r_mem[addr[i*ADDR_W +: MW]] : '0;
        end
    end
    // rotate priority and count conflict cycles whenever any write was denied
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr       <= '0;
            r_conflict_cnt <= '0;
        end else if (w_deny) begin
            r_rr_ptr       <= (r_rr_ptr == PW'(NUM_CORES-1)) ? '0 : r_rr_ptr + 1'b1;
            r_conflict_cnt <= (r_conflict_cnt == 16'hFFFF) ? r_conflict_cnt : r_conflict_cnt + 16'd1;
        end
    end
    assign gnt          = w_gnt;
    assign rdata        = r_rdata;
    assign rvalid       = r_rvalid;
    assign conflict_cnt = r_conflict_cnt;
endmodule
